// File: rtl/board_checker.sv
// board_checker
//   Decides whether a 9x9 board is solved. A rising edge of check_flag starts one
//   scan of all 27 groups (9 rows, 9 columns, 9 3x3 boxes) through a synchronous
//   board read port with 1-cycle latency. Each group must hold exactly 1..9.
//
// Ports
//   clka        clock, all state updates on posedge
//   restart     asynchronous active-high reset
//   check_flag  controller level; its rising edge (while idle) starts a scan
//   rd_en       board read strobe
//   rd_addr     board read address, row*9+col
//   rd_data     cell value, valid the cycle after rd_en/rd_addr
//   busy        high from start until done, inclusive
//   done        1-cycle pulse, result valid
//   solved      1 when the last scan found no error; held until next start
//   err_group   first failing group (0-8 rows, 9-17 cols, 18-26 boxes), 31 = none
//
// States
//   state  | meaning
//   IDLE   | waiting for a check_flag rising edge
//   SCAN   | issuing one read per cycle, 243 in total
//   DRAIN  | reads stopped, waiting for in-flight data to be consumed
//   DONE   | result valid, done pulse
module board_checker #(
  parameter int VAL_W        = 4,
  parameter int ADDR_W       = 7,
  parameter int ABORT_ON_ERR = 0
) (
  input  logic              clka,
  input  logic              restart,
  input  logic              check_flag,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [VAL_W-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic              solved,
  output logic [4:0]        err_group
);

  localparam logic [4:0] NONE = 5'd31;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t     state_q, state_d;
  logic       chk_q;
  logic [4:0] g_q, g_d;
  logic [3:0] e_q, e_d;
  logic [3:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic       p_vld_q, p_vld_d;
  logic [4:0] p_grp_q, p_grp_d;
  logic [3:0] p_e_q, p_e_d;
  logic [8:0] seen_q, seen_d;
  logic [4:0] err_q, err_d;
  logic       solved_q, solved_d;

  logic       start;
  logic       last_rd;
  logic       cell_bad;
  logic [8:0] hit;
  logic [8:0] seen_eff;

  assign start   = check_flag && !chk_q && (state_q == S_IDLE);
  assign last_rd = (g_q == 5'd26) && (e_q == 4'd8);

  // One-hot of the consumed value; all-zero means 0 or >9.
  always_comb begin
    hit = '0;
    for (int v = 1; v <= 9; v++) begin
      if (rd_data == VAL_W'(v)) hit[v-1] = 1'b1;
    end
    seen_eff = (p_e_q == 4'd0) ? 9'd0 : seen_q;
    cell_bad = p_vld_q && ((hit == 9'd0) || ((hit & seen_eff) != 9'd0));
  end

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    e_d      = e_q;
    row_d    = row_q;
    col_d    = col_q;
    p_vld_d  = (state_q == S_SCAN);
    p_grp_d  = g_q;
    p_e_d    = e_q;
    seen_d   = seen_q;
    err_d    = err_q;
    solved_d = solved_q;

    if (p_vld_q) begin
      seen_d = seen_eff | hit;
      if (cell_bad && (err_q == NONE)) err_d = p_grp_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SCAN;
          g_d      = 5'd0;
          e_d      = 4'd0;
          row_d    = 4'd0;
          col_d    = 4'd0;
          solved_d = 1'b0;
          err_d    = NONE;
        end
      end
      S_SCAN: begin
        if (last_rd) begin
          state_d = S_DRAIN;
        end else if (e_q == 4'd8) begin
          e_d = 4'd0;
          g_d = g_q + 5'd1;
          if (g_q < 5'd8) begin
            row_d = row_q + 4'd1;
            col_d = 4'd0;
          end else if (g_q == 5'd8 || g_q == 5'd17) begin
            row_d = 4'd0;
            col_d = 4'd0;
          end else if (g_q < 5'd17) begin
            row_d = 4'd0;
            col_d = col_q + 4'd1;
          end else if (col_q == 4'd8) begin
            // last box of a band: step down to the next band
            row_d = row_q + 4'd1;
            col_d = 4'd0;
          end else begin
            // next box in the same band: back to its top row
            row_d = row_q - 4'd2;
            col_d = col_q + 4'd1;
          end
        end else begin
          e_d = e_q + 4'd1;
          if (g_q < 5'd9) begin
            col_d = col_q + 4'd1;
          end else if (g_q < 5'd18) begin
            row_d = row_q + 4'd1;
          end else if (e_q == 4'd2 || e_q == 4'd5) begin
            row_d = row_q + 4'd1;
            col_d = col_q - 4'd2;
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end
      S_DRAIN: begin
        if (!p_vld_q) begin
          state_d  = S_DONE;
          solved_d = (err_q == NONE);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Early finish: stop issuing and drop the read already in flight.
    if (ABORT_ON_ERR != 0 && cell_bad) begin
      state_d = S_DRAIN;
      p_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state_q  <= S_IDLE;
      chk_q    <= 1'b0;
      g_q      <= 5'd0;
      e_q      <= 4'd0;
      row_q    <= 4'd0;
      col_q    <= 4'd0;
      p_vld_q  <= 1'b0;
      p_grp_q  <= 5'd0;
      p_e_q    <= 4'd0;
      seen_q   <= 9'd0;
      err_q    <= NONE;
      solved_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      chk_q    <= check_flag;
      g_q      <= g_d;
      e_q      <= e_d;
      row_q    <= row_d;
      col_q    <= col_d;
      p_vld_q  <= p_vld_d;
      p_grp_q  <= p_grp_d;
      p_e_q    <= p_e_d;
      seen_q   <= seen_d;
      err_q    <= err_d;
      solved_q <= solved_d;
    end
  end

  assign rd_en     = (state_q == S_SCAN);
  assign rd_addr   = ADDR_W'(row_q) * ADDR_W'(9) + ADDR_W'(col_q);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign solved    = solved_q;
  assign err_group = err_q;

endmodule

// File: tb/tb_board_checker.sv
module tb_board_checker;

  logic       clka = 1'b0;
  logic       restart;
  logic       cf_a, cf_b;
  logic       rd_en_a, rd_en_b;
  logic [6:0] rd_addr_a, rd_addr_b;
  logic [3:0] rd_data_a, rd_data_b;
  logic       busy_a, busy_b, done_a, done_b, solved_a, solved_b;
  logic [4:0] err_a, err_b;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] mem [0:80];
  logic [6:0] exp_q[$];
  logic [6:0] obs_q[$];

  always #5 clka = ~clka;

  board_checker #(.VAL_W(4), .ADDR_W(7), .ABORT_ON_ERR(0)) dut (
    .clka(clka), .restart(restart), .check_flag(cf_a), .rd_en(rd_en_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .busy(busy_a), .done(done_a),
    .solved(solved_a), .err_group(err_a));

  board_checker #(.VAL_W(4), .ADDR_W(7), .ABORT_ON_ERR(1)) dut_ab (
    .clka(clka), .restart(restart), .check_flag(cf_b), .rd_en(rd_en_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .busy(busy_b), .done(done_b),
    .solved(solved_b), .err_group(err_b));

  // board memory, synchronous read with 1-cycle latency
  always @(posedge clka) begin
    if (rd_en_a) rd_data_a <= mem[rd_addr_a];
    if (rd_en_b) rd_data_b <= mem[rd_addr_b];
  end

  function automatic int addr_of(int g, int e);
    int k;
    if (g < 9) return g * 9 + e;
    if (g < 18) return e * 9 + (g - 9);
    k = g - 18;
    return (3 * (k / 3) + e / 3) * 9 + 3 * (k % 3) + e % 3;
  endfunction

  // read index of the first erroring cell in scan order, -1 if none
  function automatic int first_err(output int grp);
    logic [15:0] seen;
    int v;
    grp = 31;
    for (int g = 0; g < 27; g++) begin
      seen = '0;
      for (int e = 0; e < 9; e++) begin
        v = int'(mem[addr_of(g, e)]);
        if (v == 0 || v > 9 || seen[v]) begin
          grp = g;
          return g * 9 + e;
        end
        seen[v] = 1'b1;
      end
    end
    return -1;
  endfunction

  task automatic load_board();
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        mem[r * 9 + c] = 4'(((r * 3 + r / 3 + c) % 9) + 1);
  endtask

  task automatic push_expected(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(7'(addr_of(i / 9, i % 9)));
  endtask

  // Starts a scan on one DUT and observes ncyc cycles (k = sample after edge E_k).
  task automatic run_scan(input bit ab, input int ncyc, output int done_at,
                          output int done_cnt, output int busy_cnt, output int n_rd);
    obs_q.delete();
    done_at = -1; done_cnt = 0; busy_cnt = 0; n_rd = 0;
    @(negedge clka);
    if (ab) cf_b = 1'b1; else cf_a = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clka);
      @(negedge clka);
      if (ab ? rd_en_b : rd_en_a) begin
        obs_q.push_back(ab ? rd_addr_b : rd_addr_a);
        n_rd++;
      end
      if (ab ? busy_b : busy_a) busy_cnt++;
      if (ab ? done_b : done_a) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
    end
    cf_a = 1'b0;
    cf_b = 1'b0;
    repeat (3) @(negedge clka);
  endtask

  task automatic test_reset();
    restart = 1'b0; cf_a = 1'b0; cf_b = 1'b0;
    #1 restart = 1'b1;
    #1;
    vectors++; if (rd_en_a !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en got %b want 0", rd_en_a); end
    vectors++; if (rd_addr_a !== 7'd0) begin miscompares++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr_a); end
    vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy_a); end
    vectors++; if (done_a !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done_a); end
    vectors++; if (solved_a !== 1'b0) begin miscompares++; $display("FAIL reset_solved got %b want 0", solved_a); end
    vectors++; if (err_a !== 5'd31) begin miscompares++; $display("FAIL reset_err got %0d want 31", err_a); end
    repeat (3) @(negedge clka);
    restart = 1'b0;
    repeat (2) @(negedge clka);
  endtask

  task automatic test_solved();
    int done_at, done_cnt, busy_cnt, n_rd;
    logic [6:0] ea, oa;
    load_board();
    push_expected(243);
    run_scan(1'b0, 260, done_at, done_cnt, busy_cnt, n_rd);
    vectors++; if (n_rd !== 243) begin miscompares++; $display("FAIL solved_nreads got %0d want 243", n_rd); end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      ea = exp_q.pop_front();
      oa = obs_q.pop_front();
      vectors++;
      if (oa !== ea) begin miscompares++; $display("FAIL scan_order read %0d got %0d want %0d", i, oa, ea); end
    end
    vectors++; if (done_at !== 245) begin miscompares++; $display("FAIL solved_done_edge got %0d want 245", done_at); end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL solved_done_count got %0d want 1", done_cnt); end
    vectors++; if (busy_cnt !== 246) begin miscompares++; $display("FAIL solved_busy_cycles got %0d want 246", busy_cnt); end
    vectors++; if (solved_a !== 1'b1) begin miscompares++; $display("FAIL solved_flag got %b want 1", solved_a); end
    vectors++; if (err_a !== 5'd31) begin miscompares++; $display("FAIL solved_err got %0d want 31", err_a); end
  endtask

  task automatic test_bad_board(input int which);
    int done_at, done_cnt, busy_cnt, n_rd;
    logic [4:0] want;
    logic [3:0] t;
    load_board();
    if (which == 0) begin
      t = mem[0]; mem[0] = mem[1]; mem[1] = t; want = 5'd9;
    end else if (which == 1) begin
      mem[80] = 4'd0; want = 5'd8;
    end else begin
      mem[40] = 4'd10; want = 5'd4;
    end
    run_scan(1'b0, 260, done_at, done_cnt, busy_cnt, n_rd);
    vectors++; if (err_a !== want) begin miscompares++; $display("FAIL bad%0d_err got %0d want %0d", which, err_a, want); end
    vectors++; if (solved_a !== 1'b0) begin miscompares++; $display("FAIL bad%0d_solved got %b want 0", which, solved_a); end
    vectors++; if (done_at !== 245) begin miscompares++; $display("FAIL bad%0d_done_edge got %0d want 245", which, done_at); end
    vectors++; if (n_rd !== 243) begin miscompares++; $display("FAIL bad%0d_nreads got %0d want 243", which, n_rd); end
  endtask

  task automatic test_hold_high();
    int done_cnt = 0;
    int done_at = -1;
    load_board();
    @(negedge clka);
    cf_a = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(posedge clka);
      @(negedge clka);
      if (done_a) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k == 99) cf_a = 1'b0;
      if (k == 100) cf_a = 1'b1;
    end
    cf_a = 1'b0;
    repeat (3) @(negedge clka);
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL hold_done_count got %0d want 1", done_cnt); end
    vectors++; if (done_at !== 245) begin miscompares++; $display("FAIL hold_done_edge got %0d want 245", done_at); end
  endtask

  task automatic test_restart();
    int done_at, done_cnt, busy_cnt, n_rd;
    int stray = 0;
    load_board();
    @(negedge clka);
    cf_a = 1'b1;
    for (int k = 0; k <= 100; k++) begin
      @(posedge clka);
      @(negedge clka);
    end
    restart = 1'b1;
    cf_a = 1'b0;
    #1;
    vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy_a); end
    vectors++; if (rd_en_a !== 1'b0) begin miscompares++; $display("FAIL rst_rd_en got %b want 0", rd_en_a); end
    vectors++; if (rd_addr_a !== 7'd0) begin miscompares++; $display("FAIL rst_rd_addr got %0d want 0", rd_addr_a); end
    vectors++; if (err_a !== 5'd31) begin miscompares++; $display("FAIL rst_err got %0d want 31", err_a); end
    vectors++; if (solved_a !== 1'b0) begin miscompares++; $display("FAIL rst_solved got %b want 0", solved_a); end
    repeat (2) @(negedge clka);
    restart = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clka);
      if (done_a || busy_a) stray++;
    end
    vectors++; if (stray !== 0) begin miscompares++; $display("FAIL rst_no_done got %0d active cycles want 0", stray); end
    run_scan(1'b0, 260, done_at, done_cnt, busy_cnt, n_rd);
    vectors++; if (done_at !== 245) begin miscompares++; $display("FAIL rst_rescan_done got %0d want 245", done_at); end
    vectors++; if (n_rd !== 243) begin miscompares++; $display("FAIL rst_rescan_nreads got %0d want 243", n_rd); end
    vectors++; if (solved_a !== 1'b1) begin miscompares++; $display("FAIL rst_rescan_solved got %b want 1", solved_a); end
  endtask

  task automatic test_abort(input int which);
    int done_at, done_cnt, busy_cnt, n_rd, idx, grp;
    logic [6:0] ea, oa;
    load_board();
    if (which == 0) mem[0] = 4'd0; else mem[40] = 4'd10;
    idx = first_err(grp);
    push_expected(idx + 2);
    run_scan(1'b1, idx + 20, done_at, done_cnt, busy_cnt, n_rd);
    vectors++; if (n_rd !== idx + 2) begin miscompares++; $display("FAIL abort%0d_nreads got %0d want %0d", which, n_rd, idx + 2); end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      ea = exp_q.pop_front();
      oa = obs_q.pop_front();
      vectors++;
      if (oa !== ea) begin miscompares++; $display("FAIL abort%0d_order read %0d got %0d want %0d", which, i, oa, ea); end
    end
    vectors++; if (done_at !== idx + 3) begin miscompares++; $display("FAIL abort%0d_done_edge got %0d want %0d", which, done_at, idx + 3); end
    vectors++; if (busy_cnt !== idx + 4) begin miscompares++; $display("FAIL abort%0d_busy got %0d want %0d", which, busy_cnt, idx + 4); end
    vectors++; if (err_b !== 5'(grp)) begin miscompares++; $display("FAIL abort%0d_err got %0d want %0d", which, err_b, grp); end
    vectors++; if (solved_b !== 1'b0) begin miscompares++; $display("FAIL abort%0d_solved got %b want 0", which, solved_b); end
  endtask

  initial begin
    test_reset();
    test_solved();
    test_bad_board(0);
    test_bad_board(1);
    test_bad_board(2);
    test_hold_high();
    test_restart();
    test_abort(0);
    test_abort(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
